// File: rtl/rv32i_hazard_ctrl.sv
// RV32I pipeline hazard controller: load-use bubble, taken-branch flush, memory-wait stall/timeout.
// Define HAZARD_PERF_CNT_EN to add saturating stall_cycles / flush_count performance counters.
module rv32i_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_reg,
  input  logic [4:0]       id_rs2_reg,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_is_load,
  input  logic             ex_wb_en,
  input  logic [4:0]       ex_wb_reg,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_target,
  input  logic             mem_busy,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             id_flush,
  output logic             ex_bubble,
  output logic             pc_redirect,
  output logic [31:0]      pc_redirect_addr,
  output logic             timeout_err,
  output logic [1:0]       state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StFlush   = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;
  localparam logic [1:0] StError   = 2'd3;

  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(MEM_TIMEOUT);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            flush_pend_q, flush_pend_d;
  logic            load_use;

  assign state = state_q;

  // x0 is never a real producer, so a zero destination can never create a hazard
  assign load_use = ex_is_load && ex_wb_en && (ex_wb_reg != 5'd0) &&
                    ((id_rs1_used && (id_rs1_reg == ex_wb_reg)) ||
                     (id_rs2_used && (id_rs2_reg == ex_wb_reg)));

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    flush_pend_d     = flush_pend_q;
    if_stall         = 1'b0;
    id_stall         = 1'b0;
    ex_stall         = 1'b0;
    mem_stall        = 1'b0;
    id_flush         = 1'b0;
    ex_bubble        = 1'b0;
    pc_redirect      = 1'b0;
    timeout_err      = 1'b0;
    pc_redirect_addr = 32'h0;

    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          {if_stall, id_stall, ex_stall, mem_stall} = 4'hf;
          flush_pend_d = 1'b0;
          state_d      = StMemWait;
        end else if (ex_branch_taken) begin
          pc_redirect = 1'b1;
          id_flush    = 1'b1;
          ex_bubble   = 1'b1;
          state_d     = StFlush;
        end else if (load_use) begin
          if_stall  = 1'b1;
          id_stall  = 1'b1;
          ex_bubble = 1'b1;
        end
      end
      StFlush: begin
        // Squash the word the synchronous IMEM already fetched from the old path
        if (mem_busy) begin
          {if_stall, id_stall, ex_stall, mem_stall} = 4'hf;
          flush_pend_d = 1'b1;
          state_d      = StMemWait;
        end else begin
          id_flush = 1'b1;
          state_d  = StRun;
        end
      end
      StMemWait: begin
        {if_stall, id_stall, ex_stall, mem_stall} = 4'hf;
        if (mem_busy) begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
          if (wait_cnt_d == TimeoutCnt) state_d = StError;
        end else begin
          wait_cnt_d   = '0;
          flush_pend_d = 1'b0;
          state_d      = flush_pend_q ? StFlush : StRun;
        end
      end
      StError: begin
        {if_stall, id_stall, ex_stall, mem_stall} = 4'hf;
        timeout_err = 1'b1;
      end
    endcase

    if (!reset) begin
      {if_stall, id_stall, ex_stall, mem_stall} = 4'h0;
      id_flush    = 1'b0;
      ex_bubble   = 1'b0;
      pc_redirect = 1'b0;
      timeout_err = 1'b0;
    end
    if (pc_redirect) pc_redirect_addr = ex_target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StRun;
      wait_cnt_q   <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (if_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (pc_redirect && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Scoreboard bench for rv32i_hazard_ctrl (MEM_TIMEOUT=4); perf counters tested when
// HAZARD_PERF_CNT_EN is defined.
module tb_rv32i_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1_reg, id_rs2_reg, ex_wb_reg;
  logic        id_rs1_used, id_rs2_used, ex_is_load, ex_wb_en, ex_branch_taken, mem_busy;
  logic [31:0] ex_target;
  logic        if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_bubble, pc_redirect;
  logic        timeout_err;
  logic [31:0] pc_redirect_addr;
  logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int checks = 0;
  int failures = 0;

  // Flag vector: {if,id,ex,mem stall, id_flush, ex_bubble, pc_redirect, timeout_err, state}
  localparam logic [9:0] NONE = 10'b0000_00_0_0_00;
  localparam logic [9:0] LU   = 10'b1100_01_0_0_00;
  localparam logic [9:0] BR   = 10'b0000_11_1_0_00;
  localparam logic [9:0] FL   = 10'b0000_10_0_0_01;
  localparam logic [9:0] SRUN = 10'b1111_00_0_0_00;
  localparam logic [9:0] SFL  = 10'b1111_00_0_0_01;
  localparam logic [9:0] MW   = 10'b1111_00_0_0_10;
  localparam logic [9:0] ERR  = 10'b1111_00_0_1_11;

  typedef struct packed {
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic ld; logic wb; logic [4:0] wbr; logic br; logic [31:0] tgt; logic busy;
  } stim_t;

  typedef struct packed {
    logic [9:0]  flags;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];

  rv32i_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs1_reg       (id_rs1_reg),
    .id_rs2_reg       (id_rs2_reg),
    .id_rs1_used      (id_rs1_used),
    .id_rs2_used      (id_rs2_used),
    .ex_is_load       (ex_is_load),
    .ex_wb_en         (ex_wb_en),
    .ex_wb_reg        (ex_wb_reg),
    .ex_branch_taken  (ex_branch_taken),
    .ex_target        (ex_target),
    .mem_busy         (mem_busy),
    .if_stall         (if_stall),
    .id_stall         (id_stall),
    .ex_stall         (ex_stall),
    .mem_stall        (mem_stall),
    .id_flush         (id_flush),
    .ex_bubble        (ex_bubble),
    .pc_redirect      (pc_redirect),
    .pc_redirect_addr (pc_redirect_addr),
    .timeout_err      (timeout_err),
    .state            (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(int rs1, int u1, int rs2, int u2, int ld, int wb, int wbr,
                               int br, int tgt, int busy);
    stim_t s;
    s.rs1 = 5'(rs1); s.u1 = 1'(u1); s.rs2 = 5'(rs2); s.u2 = 1'(u2);
    s.ld = 1'(ld); s.wb = 1'(wb); s.wbr = 5'(wbr); s.br = 1'(br);
    s.tgt = 32'(tgt); s.busy = 1'(busy);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    id_rs1_reg = s.rs1; id_rs1_used = s.u1; id_rs2_reg = s.rs2; id_rs2_used = s.u2;
    ex_is_load = s.ld; ex_wb_en = s.wb; ex_wb_reg = s.wbr;
    ex_branch_taken = s.br; ex_target = s.tgt; mem_busy = s.busy;
  endtask

  function automatic logic [9:0] obs();
    return {if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_bubble, pc_redirect,
            timeout_err, state};
  endfunction

  task automatic test_reset();
    exp_t e;
    reset = 1'b0;
    drive(mk(5, 1, 6, 1, 1, 1, 5, 1, 32'h1234, 1));
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{NONE, 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.flags) begin
        failures++; $display("FAIL reset[%0d] flags got %b want %b", i, obs(), e.flags);
      end
      checks++;
      if (pc_redirect_addr !== e.addr) begin
        failures++; $display("FAIL reset[%0d] addr got %h want %h", i, pc_redirect_addr, e.addr);
      end
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    stim_t st[5]; logic [9:0] ef[5]; exp_t e;
    st[0] = mk(5, 1, 0, 0, 1, 1, 5, 0, 0, 0);   ef[0] = LU;
    st[1] = mk(5, 1, 0, 0, 0, 1, 5, 0, 0, 0);   ef[1] = NONE;
    st[2] = mk(3, 1, 9, 1, 1, 1, 9, 0, 0, 0);   ef[2] = LU;
    st[3] = mk(9, 1, 9, 1, 1, 1, 8, 0, 0, 0);   ef[3] = NONE;
    st[4] = mk(12, 1, 0, 0, 1, 1, 12, 0, 0, 0); ef[4] = LU;
    for (int i = 0; i < 5; i++) begin
      drive(st[i]);
      sb.push_back('{ef[i], ef[i][3] ? st[i].tgt : 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.flags) begin
        failures++; $display("FAIL load_use[%0d] flags got %b want %b", i, obs(), e.flags);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_x0_unused();
    stim_t st[3]; logic [9:0] ef[3]; exp_t e;
    st[0] = mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 0); ef[0] = NONE;
    st[1] = mk(1, 1, 7, 0, 1, 1, 7, 0, 0, 0); ef[1] = NONE;
    st[2] = mk(4, 1, 4, 1, 1, 0, 4, 0, 0, 0); ef[2] = NONE;
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      sb.push_back('{ef[i], 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.flags) begin
        failures++; $display("FAIL x0_unused[%0d] flags got %b want %b", i, obs(), e.flags);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    stim_t st[3]; logic [9:0] ef[3]; exp_t e;
    st[0] = mk(5, 1, 0, 0, 1, 1, 5, 1, 32'h40, 0); ef[0] = BR;
    st[1] = mk(5, 1, 0, 0, 1, 1, 5, 1, 32'h99, 0); ef[1] = FL;
    st[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 0); ef[2] = NONE;
    for (int i = 0; i < 3; i++) begin
      drive(st[i]);
      sb.push_back('{ef[i], ef[i][3] ? st[i].tgt : 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.flags) begin
        failures++; $display("FAIL branch[%0d] flags got %b want %b", i, obs(), e.flags);
      end
      checks++;
      if (pc_redirect_addr !== e.addr) begin
        failures++; $display("FAIL branch[%0d] addr got %h want %h", i, pc_redirect_addr, e.addr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    stim_t st[7]; logic [9:0] ef[7]; exp_t e;
    st[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0); ef[0] = BR;
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1); ef[1] = SFL;
    st[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1); ef[2] = MW;
    st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1); ef[3] = MW;
    st[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0); ef[4] = MW;
    st[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0); ef[5] = FL;
    st[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 0); ef[6] = NONE;
    for (int i = 0; i < 7; i++) begin
      drive(st[i]);
      sb.push_back('{ef[i], ef[i][3] ? st[i].tgt : 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.flags) begin
        failures++; $display("FAIL mem_wait[%0d] flags got %b want %b", i, obs(), e.flags);
      end
      checks++;
      if (pc_redirect_addr !== e.addr) begin
        failures++; $display("FAIL mem_wait[%0d] addr got %h want %h", i, pc_redirect_addr, e.addr);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [9:0] ef[7]; exp_t e;
    ef = '{SRUN, MW, MW, MW, MW, ERR, ERR};
    for (int i = 0; i < 7; i++) begin
      drive(mk(5, 1, 0, 0, 1, 1, 5, 1, 32'h80, (i < 6) ? 1 : 0));
      sb.push_back('{ef[i], 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.flags) begin
        failures++; $display("FAIL timeout[%0d] flags got %b want %b", i, obs(), e.flags);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    sb.push_back('{NONE, 32'h0});
    #2;
    e = sb.pop_front();
    checks++;
    if (obs() !== e.flags) begin
      failures++; $display("FAIL timeout_reset flags got %b want %b", obs(), e.flags);
    end
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{NONE, 32'h0});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs() !== e.flags) begin
      failures++; $display("FAIL timeout_after_reset flags got %b want %b", obs(), e.flags);
    end
    @(posedge clk); #1;
  endtask

  // Reset landing in FLUSH (mode 0) or MEM_WAIT (mode 1) must drop the pending work.
  task automatic test_reset_mid_op();
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      drive(mk(0, 0, 0, 0, 0, 0, 0, m == 0 ? 1 : 0, 32'h100, m));
      @(posedge clk); #1;
      if (m == 1) begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 1));
        @(posedge clk); #1;
      end
      reset = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 1));
      sb.push_back('{NONE, 32'h0});
      #2;
      e = sb.pop_front();
      checks++;
      if (obs() !== e.flags || pc_redirect_addr !== e.addr) begin
        failures++;
        $display("FAIL mid_reset[%0d] flags got %b/%h want %b/%h", m, obs(), pc_redirect_addr,
                 e.flags, e.addr);
      end
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      reset = 1'b1;
      @(posedge clk); #1;
      sb.push_back('{NONE, 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.flags) begin
        failures++; $display("FAIL mid_reset_release[%0d] flags got %b want %b", m, obs(), e.flags);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[6]; logic [9:0] ef[6]; exp_t e;
    st[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0); ef[0] = BR;
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0); ef[1] = FL;
    st[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 0);  ef[2] = BR;
    st[3] = mk(2, 1, 0, 0, 1, 1, 2, 0, 0, 0);       ef[3] = FL;
    st[4] = mk(2, 1, 0, 0, 1, 1, 2, 0, 0, 0);       ef[4] = LU;
    st[5] = mk(0, 0, 3, 1, 1, 1, 3, 0, 0, 0);       ef[5] = LU;
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      sb.push_back('{ef[i], ef[i][3] ? st[i].tgt : 32'h0});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs() !== e.flags) begin
        failures++; $display("FAIL b2b[%0d] flags got %b want %b", i, obs(), e.flags);
      end
      checks++;
      if (pc_redirect_addr !== e.addr) begin
        failures++; $display("FAIL b2b[%0d] addr got %h want %h", i, pc_redirect_addr, e.addr);
      end
      @(posedge clk); #1;
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    stim_t st[6];
    reset = 1'b0;
    #2;
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      failures++; $display("FAIL perf_reset got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    st[0] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0);
    st[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    st[2] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h44, 0);
    st[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    st[4] = mk(6, 1, 0, 0, 1, 1, 6, 0, 0, 0);
    st[5] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(st[i]);
      @(posedge clk); #1;
    end
    checks++;
    if (flush_count !== 32'd2) begin
      failures++; $display("FAIL perf_flush_count got %0d want 2", flush_count);
    end
    checks++;
    if (stall_cycles !== 32'd1) begin
      failures++; $display("FAIL perf_stall_cycles got %0d want 1", stall_cycles);
    end
    reset = 1'b0;
    #2;
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      failures++; $display("FAIL perf_midreset got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_x0_unused();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_hazard_ctrl.md
RV32I_HAZARD_CTRL -- requirements
Module: rv32i_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: max consecutive mem_busy cycles before error.
REQ-002 SHALL have parameter CNT_W, default 32: width of performance counters.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1_reg and id_rs2_reg, input, 5 each: source registers of the instruction in ID.
REQ-006 SHALL have ports id_rs1_used and id_rs2_used, input, 1 each: the ID instruction reads that source.
REQ-007 SHALL have ports ex_is_load (1), ex_wb_en (1) and ex_wb_reg (5), input: state of the instruction in EX.
REQ-008 SHALL have ports ex_branch_taken (1) and ex_target (32), input: taken branch or jump resolved in EX, and its target.
REQ-009 SHALL have port mem_busy, input, 1: data memory not ready this cycle.
REQ-010 SHALL have ports if_stall, id_stall, ex_stall and mem_stall, output, 1 each: hold the pipeline register feeding that stage.
REQ-011 SHALL have ports id_flush and ex_bubble, output, 1 each: clear IF/ID; load a NOP into ID/EX.
REQ-012 SHALL have ports pc_redirect (1) and pc_redirect_addr (32), output: load PC from the target.
REQ-013 SHALL have ports timeout_err (1) and state (2), output: sticky error flag and FSM state.

Function
REQ-014 SHALL implement FSM states RUN=0, FLUSH=1, MEM_WAIT=2, ERROR=3, held in a register, with all other outputs combinational from state and inputs.
REQ-015 In RUN, load-use SHALL be detected as: ex_is_load & ex_wb_en & ex_wb_reg!=0 & ((id_rs1_used & rs1==ex_wb_reg) | (id_rs2_used & rs2==ex_wb_reg)).
REQ-016 On a load-use hit, SHALL assert if_stall, id_stall and ex_bubble for exactly that cycle and remain in RUN (one bubble; the MEM forwarding path covers the next cycle).
REQ-017 In RUN with ex_branch_taken=1, SHALL assert pc_redirect with pc_redirect_addr=ex_target, assert id_flush and ex_bubble, and go to FLUSH.
REQ-018 A branch SHALL take priority over load-use in the same cycle (no load-use stall is asserted).
REQ-019 In FLUSH, SHALL assert id_flush for one cycle to squash the word already in flight from the synchronous instruction RAM, ignore ex_branch_taken and load-use, and return to RUN.
REQ-020 pc_redirect_addr SHALL be 0 whenever pc_redirect=0.
REQ-021 mem_busy=1 in RUN or FLUSH SHALL override all other events.
REQ-022 When mem_busy overrides, all four stalls SHALL be asserted that cycle with no redirect, bubble or flush, and the FSM SHALL go to MEM_WAIT.
REQ-023 A flush pending from FLUSH SHALL be re-issued for one cycle after MEM_WAIT exits.
REQ-024 In MEM_WAIT, SHALL assert all four stalls and increment an internal wait counter (width clog2(MEM_TIMEOUT+1)) each cycle mem_busy=1.
REQ-025 In MEM_WAIT, mem_busy=0 SHALL clear the wait counter and return to RUN, or to FLUSH if a flush is pending.
REQ-026 When the wait counter equals MEM_TIMEOUT with mem_busy still 1, SHALL go to ERROR.
REQ-027 ERROR SHALL be terminal until reset: timeout_err=1 and all four stalls held at 1.
REQ-028 Register sources equal to x0 SHALL never cause a stall.

Reset
REQ-029 reset=0 SHALL asynchronously force state=RUN, clear the wait counter and pending-flush flag, and clear timeout_err.
REQ-030 While reset=0, all stall, flush, bubble and redirect outputs SHALL be 0 and pc_redirect_addr SHALL be 0.
REQ-031 Reset asserted mid-MEM_WAIT or mid-FLUSH SHALL discard the in-progress operation; the first cycle after release SHALL be RUN.

Configuration
REQ-032 With HAZARD_PERF_CNT_EN defined, SHALL add outputs stall_cycles and flush_count, CNT_W each, cleared by reset.
REQ-033 stall_cycles SHALL increment on any cycle with if_stall=1; flush_count SHALL increment on each pc_redirect.
REQ-034 Both counters SHALL saturate at all-ones.
REQ-035 Without HAZARD_PERF_CNT_EN, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Load-use: EX lw x5 (ex_is_load=1, ex_wb_en=1, ex_wb_reg=5), ID rs1=5 used -> if_stall=id_stall=ex_bubble=1 for 1 cycle; next cycle with ex_is_load=0 -> all 0.
REQ-037 x0 and unused source: ex_wb_reg=0 with rs1=0 used, and ex_wb_reg=7 with rs2=7 but id_rs2_used=0 -> no stall in either case.
REQ-038 Branch: ex_branch_taken=1, ex_target=0x00000040 -> pc_redirect=1 with addr 0x40 for 1 cycle; id_flush=1 for 2 cycles; state RUN->FLUSH->RUN; same-cycle load-use ignored.
REQ-039 Mem wait: mem_busy=1 for 3 cycles arriving in FLUSH -> 4 stalls high for 3 cycles, state=2, then one id_flush cycle (FLUSH), then RUN.
REQ-040 Timeout: MEM_TIMEOUT=4, mem_busy held high -> ERROR after the 4th wait cycle, timeout_err=1 and stalls held until reset=0, then RUN with all outputs 0.
REQ-041 With HAZARD_PERF_CNT_EN: two branches plus one load-use -> flush_count=2, stall_cycles=1; a mid-test reset clears both to 0.
